mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
//
// PURPOSE
//   Shares one backing memory port (M9K or SDRAM controller) among NUM_PORTS
//   mem_handle requesters. Arbitration is round-robin, one transaction at a time.
//   Each access is bounds-checked against the requester's region before issue.
//   Sits between the worker's compute/DMA units and the memory backend.
//   mem_handle fields are flattened into packed per-port vectors; port i occupies slice i.
//
// PARAMETERS
//   NUM_PORTS  default `NUM_PORTS (5)   number of requesters (6 with DPR)
//   ADDR_W     default `ADDR_SIZE (23)  address width
//   DATA_W     default `DATA_SIZE (32)  data word width
//
// PORTS
//   clk               in   1                 single clock; all logic on posedge
//   rst_l             in   1                 reset, asynchronous, active-low
//   req_r_en          in   NUM_PORTS         per-port read request (level)
//   req_w_en          in   NUM_PORTS         per-port write request (level)
//   req_ptr           in   NUM_PORTS*ADDR_W  per-port access address
//   req_region_begin  in   NUM_PORTS*ADDR_W  per-port region lower bound (inclusive)
//   req_region_end    in   NUM_PORTS*ADDR_W  per-port region upper bound (inclusive)
//   req_data_store    in   NUM_PORTS*DATA_W  per-port write data
//   req_avail         out  NUM_PORTS         arbiter can accept a request
//   req_done          out  NUM_PORTS         one-cycle completion pulse to granted port
//   req_err           out  NUM_PORTS         qualifies done: access rejected, no memory op
//   req_data_load     out  NUM_PORTS*DATA_W  per-port read data, held until next read done
//   mem_req           out  1                 backend request, held until mem_ack
//   mem_we            out  1                 1 = write, 0 = read; valid with mem_req
//   mem_addr          out  ADDR_W            backend address; valid with mem_req
//   mem_wdata         out  DATA_W            backend write data; valid with mem_req
//   mem_ack           in   1                 backend completion; mem_rdata valid this cycle
//   mem_rdata         in   DATA_W            backend read data
//
// BEHAVIOUR
//   Reset (async, rst_l=0)
//     - All outputs 0; state=IDLE; priority pointer=0; mem_req drops without waiting for ack.
//   Request validity
//     - Port i is requesting when req_r_en[i] | req_w_en[i].
//     - Request is invalid (error) if both enables are high, or if ptr<region_begin, or if
//       ptr>region_end. Comparisons are unsigned.
//   FSM
//     - IDLE: req_avail = all ones. Grant the first requesting port at or after prio
//       (wrap modulo NUM_PORTS) and latch grant/ptr/we/wdata. Invalid request -> ERR;
//       valid -> ISSUE. No request -> stay.
//     - ISSUE: mem_req=1 with latched addr/we/wdata. mem_ack=1 -> DONE, capturing mem_rdata
//       into req_data_load[g] on reads. mem_ack may arrive in the first ISSUE cycle.
//     - DONE: req_done[g]=1 for exactly one cycle -> IDLE.
//     - ERR: req_done[g]=1 and req_err[g]=1 for one cycle; no memory access -> IDLE.
//     - On leaving DONE/ERR: prio = (g+1) mod NUM_PORTS.
//   Timing and handshake
//     - req_avail = 0 outside IDLE.
//     - Minimum latency is 3 cycles: request seen in IDLE (c0), ISSUE (c1) with ack,
//       done (c2).
//     - Requester must drop its enable on the edge ending its done cycle; an enable still
//       high in the following IDLE starts a new transaction.
//     - Request inputs are sampled only in IDLE. Changes while granted are ignored.
//       If the requester deasserts mid-transaction, the transaction still completes
//       and done still pulses.
//     - mem_ack outside ISSUE is ignored.
//     - req_data_load of non-granted ports never changes; writes leave req_data_load[g] unchanged.
//     - No timeout: a stuck backend holds the arbiter in ISSUE until reset.
//
// TESTING
//   1. Single read: port 2 reads ptr=0x10, region [0x0,0xFF], mem_ack 1 cycle after mem_req,
//      rdata=0xDEADBEEF -> mem_addr=0x10, mem_we=0, req_done[2] pulse, data_load[2]=0xDEADBEEF.
//   2. Round-robin: ports 0,1,4 hold writes from reset -> grant order 0,1,4,0...; a re-request
//      by port 0 after its done is served only after ports 1 and 4.
//   3. Bounds: port 3 ptr=0x200, region [0x100,0x1FF] -> req_done[3]=req_err[3]=1, mem_req never
//      asserted. ptr=0x1FF -> legal access issued.
//   4. Both r_en and w_en high on port 1 -> error done, no backend access.
//   5. Backend stall: mem_ack withheld 50 cycles -> mem_req/addr stable, req_avail=0 throughout;
//      same-cycle ack variant completes in 3 cycles.
//   6. Reset mid-ISSUE: rst_l low while mem_req=1 -> mem_req and all outputs 0 immediately;
//      after release, arbitration restarts at port 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing memory port among NUM_PORTS requesters.
// Round-robin grant, one transaction in flight, per-port region bounds check
// before anything reaches the backend.
//
// Backend handshake: mem_req is a valid that stays high, with mem_we/mem_addr/
// mem_wdata stable, until the cycle mem_ack is sampled high; that same cycle is
// the only one in which mem_rdata is taken. mem_ack seen while mem_req is low
// carries no meaning and is dropped.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic [NUM_PORTS-1:0]          req_r_en,
    input  logic [NUM_PORTS-1:0]          req_w_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_ptr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_region_begin,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_region_end,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_store,
    output logic [NUM_PORTS-1:0]          req_avail,
    output logic [NUM_PORTS-1:0]          req_done,
    output logic [NUM_PORTS-1:0]          req_err,
    output logic [NUM_PORTS*DATA_W-1:0]   req_data_load,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [1:0]                    dbg_state_o
);

    localparam int              PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW:0]     NP_W     = (PW + 1)'(NUM_PORTS);
    localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          prio_q;
    logic [PW-1:0]          grant_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic [NUM_PORTS-1:0]   avail_q;
    logic [NUM_PORTS-1:0]   done_q;
    logic [NUM_PORTS-1:0]   err_q;
    logic [DATA_W-1:0]      load_q [NUM_PORTS];

    logic [ADDR_W-1:0]      ptr_a  [NUM_PORTS];
    logic [ADDR_W-1:0]      beg_a  [NUM_PORTS];
    logic [ADDR_W-1:0]      end_a  [NUM_PORTS];
    logic [DATA_W-1:0]      wd_a   [NUM_PORTS];

    logic                   pick_found;
    logic [PW-1:0]          pick_idx;
    logic [PW:0]            cand;
    logic                   pick_bad;
    logic [NUM_PORTS-1:0]   pick_oh;
    logic [NUM_PORTS-1:0]   grant_oh;

    // Unpack the flattened per-port buses and repack the read-data holding registers.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign ptr_a[i] = req_ptr[i*ADDR_W +: ADDR_W];
        assign beg_a[i] = req_region_begin[i*ADDR_W +: ADDR_W];
        assign end_a[i] = req_region_end[i*ADDR_W +: ADDR_W];
        assign wd_a[i]  = req_data_store[i*DATA_W +: DATA_W];
        assign req_data_load[i*DATA_W +: DATA_W] = load_q[i];
    end

    // Round-robin pick: first requesting port at or after prio_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, prio_q} + (PW + 1)'(k);
            if (cand >= NP_W) begin
                cand = cand - NP_W;
            end
            if (!pick_found && (req_r_en[cand[PW-1:0]] || req_w_en[cand[PW-1:0]])) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    // A picked request is rejected for a read/write conflict or an address outside its region.
    assign pick_bad = (req_r_en[pick_idx] & req_w_en[pick_idx])
                    | (ptr_a[pick_idx] < beg_a[pick_idx])
                    | (ptr_a[pick_idx] > end_a[pick_idx]);
    assign pick_oh  = NUM_PORTS'(1) << pick_idx;
    assign grant_oh = NUM_PORTS'(1) << grant_q;

    // Arbiter FSM; every port-facing and backend-facing output is a register here.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            prio_q      <= '0;
            grant_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            avail_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                load_q[i] <= '0;
            end
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q     <= pick_idx;
                        mem_addr_q  <= ptr_a[pick_idx];
                        mem_we_q    <= req_w_en[pick_idx];
                        mem_wdata_q <= wd_a[pick_idx];
                        avail_q     <= '0;
                        if (pick_bad) begin
                            state_q <= ST_ERR;
                            done_q  <= pick_oh;
                            err_q   <= pick_oh;
                        end else begin
                            state_q   <= ST_ISSUE;
                            mem_req_q <= 1'b1;
                        end
                    end else begin
                        avail_q <= '1;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        done_q    <= grant_oh;
                        if (!mem_we_q) begin
                            load_q[grant_q] <= mem_rdata;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_q <= ST_IDLE;
                    avail_q <= '1;
                    prio_q  <= (grant_q == LAST_IDX) ? '0 : grant_q + PW'(1);
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_avail   = avail_q;
    assign req_done    = done_q;
    assign req_err     = err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized requesters and
// backend, compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int NP = 5;
    localparam int AW = 23;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_l = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    r_en, w_en;
    logic [NP*AW-1:0] ptr, rbeg, rend;
    logic [NP*DW-1:0] wdata;
    logic [NP-1:0]    req_avail, req_done, req_err;
    logic [NP*DW-1:0] req_data_load;
    logic             mem_req, mem_we, mem_ack;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata, mem_rdata;
    logic [1:0]       dbg_state;

    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_l(rst_l),
        .req_r_en(r_en), .req_w_en(w_en), .req_ptr(ptr),
        .req_region_begin(rbeg), .req_region_end(rend), .req_data_store(wdata),
        .req_avail(req_avail), .req_done(req_done), .req_err(req_err),
        .req_data_load(req_data_load),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    // ---------------- stimulus state ----------------
    logic [AW-1:0] s_ptr [NP];
    logic [AW-1:0] s_b   [NP];
    logic [AW-1:0] s_e   [NP];
    logic [DW-1:0] s_wd  [NP];
    logic          s_r   [NP];
    logic          s_w   [NP];
    bit            active[NP];
    bit            hold  [NP];
    bit            rand_mode = 0;
    bit            ack_noise = 1;
    bit            use_fixed = 1;
    logic [DW-1:0] fixed_rdata = 32'hDEADBEEF;
    int            withhold = 0;
    int            issue_cnt = 0;

    // ---------------- reference model ----------------
    // m_phase: 0 waiting for a request, 1 backend access outstanding,
    //          2 completion being reported, 3 rejection being reported
    int            m_phase;
    int            m_g, m_prio;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_load[NP];
    bit            m_rst;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int q_idx[$];
    int q_err[$];
    int q_cnt[$];
    logic [AW-1:0] q_addr[$];
    int mreq_cnt = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_q();
        q_idx.delete(); q_err.delete(); q_cnt.delete(); q_addr.delete();
        mreq_cnt = 0;
    endtask

    task automatic model_reset();
        m_rst = 1; m_phase = 0; m_prio = 0; m_g = 0;
        m_addr = '0; m_we = 0; m_wdata = '0;
        for (int p = 0; p < NP; p++) m_load[p] = '0;
    endtask

    task automatic model_step();
        bit found;
        int p;
        logic [AW-1:0] a, b, e;
        if (!rst_l) begin
            model_reset();
            return;
        end
        m_rst = 0;
        case (m_phase)
            0: begin
                found = 0;
                for (int k = 0; k < NP; k++) begin
                    p = (m_prio + k) % NP;
                    if (!found && (r_en[p] || w_en[p])) begin
                        found   = 1;
                        a = ptr[p*AW +: AW]; b = rbeg[p*AW +: AW]; e = rend[p*AW +: AW];
                        m_g     = p;
                        m_addr  = a;
                        m_we    = w_en[p];
                        m_wdata = wdata[p*DW +: DW];
                        m_phase = ((r_en[p] && w_en[p]) || a < b || a > e) ? 3 : 1;
                    end
                end
            end
            1: if (mem_ack) begin
                if (!m_we) m_load[m_g] = mem_rdata;
                m_phase = 2;
            end
            default: begin
                m_prio  = (m_g + 1) % NP;
                m_phase = 0;
            end
        endcase
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_outputs();
        logic [NP-1:0] e_av, e_dn, e_er;
        bit busy;
        e_av = '0; e_dn = '0; e_er = '0;
        busy = 0;
        if (!m_rst) begin
            if (m_phase == 0) e_av = '1;
            if (m_phase >= 2) e_dn[m_g] = 1'b1;
            if (m_phase == 3) e_er[m_g] = 1'b1;
            busy = (m_phase == 1);
        end
        chk("req_avail", req_avail, e_av);
        chk("req_done",  req_done,  e_dn);
        chk("req_err",   req_err,   e_er);
        chk("mem_req",   mem_req,   busy);
        if (m_rst) begin
            chk("rst_mem_addr",  mem_addr, 0);
            chk("rst_mem_we",    mem_we, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end else if (busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we",   mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        for (int p = 0; p < NP; p++) chk("req_data_load", req_data_load[p*DW +: DW], m_load[p]);
        // transaction recorder (observed side only)
        if (mem_req === 1'b1) begin
            mreq_cnt++;
            last_addr = mem_addr;
        end
        if (req_done !== '0) begin
            for (int p = NP - 1; p >= 0; p--) if (req_done[p]) begin
                q_idx.push_back(p);
                q_err.push_back(int'(req_err[p]));
            end
            q_cnt.push_back(mreq_cnt);
            q_addr.push_back(last_addr);
            mreq_cnt = 0;
        end
    endtask

    task automatic new_random_req(int p);
        int kind, sel;
        kind = $urandom_range(0, 9);
        s_r[p] = (kind <= 4);
        s_w[p] = (kind == 0) || (kind > 4);
        s_b[p] = AW'($urandom_range(0, 4000));
        s_e[p] = s_b[p] + AW'($urandom_range(0, 300));
        sel = $urandom_range(0, 7);
        case (sel)
            0: s_ptr[p] = s_b[p];
            1: s_ptr[p] = s_e[p];
            2: s_ptr[p] = s_b[p] - AW'(1);
            3: s_ptr[p] = s_e[p] + AW'(1);
            4: s_ptr[p] = AW'($urandom);
            default: s_ptr[p] = s_b[p] + AW'($urandom_range(0, int'(s_e[p] - s_b[p])));
        endcase
        s_wd[p] = $urandom;
        active[p] = 1;
    endtask

    // Requesters and backend for the coming clock edge.
    task automatic drive();
        bit is_done;
        for (int p = 0; p < NP; p++) begin
            is_done = !m_rst && (m_phase >= 2) && (m_g == p);
            if (active[p] && is_done && !hold[p]) begin
                active[p] = 0;
            end else if (active[p] && rand_mode && !m_rst && m_phase == 1 && m_g == p
                         && $urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) s_ptr[p] = AW'($urandom);
                else active[p] = 0;
            end else if (!active[p] && rand_mode && $urandom_range(0, 3) == 0) begin
                new_random_req(p);
            end
            r_en[p] = active[p] & s_r[p];
            w_en[p] = active[p] & s_w[p];
            ptr[p*AW +: AW]   = s_ptr[p];
            rbeg[p*AW +: AW]  = s_b[p];
            rend[p*AW +: AW]  = s_e[p];
            wdata[p*DW +: DW] = s_wd[p];
        end
        if (!m_rst && m_phase == 1) begin
            if (issue_cnt == 0 && rand_mode) withhold = $urandom_range(0, 3);
            issue_cnt++;
            mem_ack = (issue_cnt > withhold);
        end else begin
            issue_cnt = 0;
            mem_ack = ack_noise && ($urandom_range(0, 7) == 0);
        end
        mem_rdata = use_fixed ? fixed_rdata : $urandom;
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            drive();
            model_step();
        end
    endtask

    task automatic reset_cycle(int n);
        rst_l = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            drive();
        end
        rst_l = 1'b1;
        model_step();
    endtask

    task automatic start_req(int p, bit rd, bit wr, int a, int b, int e, logic [DW-1:0] d);
        s_r[p] = rd; s_w[p] = wr;
        s_ptr[p] = AW'(a); s_b[p] = AW'(b); s_e[p] = AW'(e);
        s_wd[p] = d;
        active[p] = 1;
    endtask

    task automatic expect_txn(string name, int n, int idx, int err, int cnt);
        if (q_idx.size() <= n) begin
            chk({name, "_present"}, q_idx.size(), n + 1);
        end else begin
            chk({name, "_port"}, q_idx[n], idx);
            chk({name, "_err"},  q_err[n], err);
            if (cnt >= 0) chk({name, "_mem_req_cycles"}, q_cnt[n], cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            s_ptr[p] = '0; s_b[p] = '0; s_e[p] = '0; s_wd[p] = '0;
            s_r[p] = 0; s_w[p] = 0; active[p] = 0; hold[p] = 0;
        end
        r_en = '0; w_en = '0; ptr = '0; rbeg = '0; rend = '0; wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        model_reset();
        #1;

        // single read on port 2, ack one cycle after mem_req
        reset_cycle(3);
        clear_q();
        withhold = 1;
        start_req(2, 1, 0, 'h10, 'h0, 'hFF, '0);
        run(8);
        expect_txn("t1", 0, 2, 0, 2);
        if (q_addr.size() > 0) chk("t1_addr", q_addr[0], 'h10);
        chk("t1_load2", req_data_load[2*DW +: DW], 32'hDEADBEEF);
        chk("t1_load0", req_data_load[0 +: DW], 0);

        // round-robin with ports 0,1,4 holding writes from reset
        withhold = 0;
        for (int p = 0; p < NP; p++) if (p == 0 || p == 1 || p == 4) begin
            start_req(p, 0, 1, 'h20 + p, 'h0, 'hFF, 32'h1000 + p);
            hold[p] = 1;
        end
        reset_cycle(2);
        clear_q();
        run(20);
        expect_txn("t2a", 0, 0, 0, 1);
        expect_txn("t2b", 1, 1, 0, 1);
        expect_txn("t2c", 2, 4, 0, 1);
        expect_txn("t2d", 3, 0, 0, 1);
        expect_txn("t2e", 4, 1, 0, 1);
        expect_txn("t2f", 5, 4, 0, 1);
        for (int p = 0; p < NP; p++) hold[p] = 0;
        run(20);

        // bounds: one past the region end is rejected, the last word is allowed
        clear_q();
        start_req(3, 0, 1, 'h200, 'h100, 'h1FF, 32'hA5A5A5A5);
        run(6);
        start_req(3, 0, 1, 'h1FF, 'h100, 'h1FF, 32'h5A5A5A5A);
        run(6);
        expect_txn("t3_out", 0, 3, 1, 0);
        expect_txn("t3_in",  1, 3, 0, 1);
        if (q_addr.size() > 1) chk("t3_addr", q_addr[1], 'h1FF);

        // read and write enables together
        clear_q();
        start_req(1, 1, 1, 'h10, 'h0, 'hFF, '0);
        run(6);
        expect_txn("t4", 0, 1, 1, 0);

        // backend stall of 50 cycles, then an immediate ack
        clear_q();
        withhold = 50;
        fixed_rdata = 32'h0BADCAFE;
        start_req(1, 1, 0, 'h44, 'h40, 'h50, '0);
        run(60);
        withhold = 0;
        start_req(1, 1, 0, 'h45, 'h40, 'h50, '0);
        run(6);
        expect_txn("t5_stall", 0, 1, 0, 51);
        expect_txn("t5_fast",  1, 1, 0, 1);
        chk("t5_load1", req_data_load[1*DW +: DW], 32'h0BADCAFE);

        // reset while the backend access is outstanding
        withhold = 1000;
        start_req(2, 1, 0, 'h30, 'h0, 'hFF, '0);
        run(4);
        chk("t6_req_before_reset", mem_req, 1);
        #2;
        active[2] = 0;
        withhold = 0;
        start_req(3, 0, 1, 'h31, 'h0, 'hFF, 32'h33);
        start_req(0, 0, 1, 'h32, 'h0, 'hFF, 32'h44);
        reset_cycle(2);
        chk("t6_load1_cleared", req_data_load[1*DW +: DW], 0);
        clear_q();
        run(10);
        expect_txn("t6_first",  0, 0, 0, 1);
        expect_txn("t6_second", 1, 3, 0, 1);

        // randomized traffic
        clear_q();
        rand_mode = 1;
        use_fixed = 0;
        run(4000);
        chk("rand_txns_seen", (q_idx.size() > 100), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
